// File: rtl/vpu_pkg.sv
// vpu_pkg: shared VPU constants and types.
//   DWIDTH_PER_EXEC : result width produced by one exec unit (multiple of 8)
//   VREG_ID_W       : vector-register index width
//   VPU_WB_DEPTH    : default writeback buffer depth (power of two, >= 2)
//   vpu_wb_entry_t  : buffered writeback entry {vreg_id, data}
package vpu_pkg;

    localparam int DWIDTH_PER_EXEC = 32;
    localparam int VREG_ID_W       = 5;
    localparam int VPU_WB_DEPTH    = 4;

    typedef struct packed {
        logic [VREG_ID_W-1:0]       vreg_id;
        logic [DWIDTH_PER_EXEC-1:0] data;
    } vpu_wb_entry_t;

endpackage

// File: rtl/vpu_wb_fifo.sv
// vpu_wb_fifo: generic synchronous FIFO, payload type T, DEPTH entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_push     : write i_data (accepted when not full, or when full and popping)
//   i_pop      : advance head (ignored when empty)
//   o_data     : head entry, read straight from the storage registers
//   o_full     : DEPTH entries held
//   o_empty    : no entries held
module vpu_wb_fifo #(
    parameter int  DEPTH = 4,
    parameter type T     = logic [7:0]
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_push,
    input  T     i_data,
    input  logic i_pop,
    output T     o_data,
    output logic o_full,
    output logic o_empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = DEPTH[AW:0];

    T              r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_full    = (r_count == FULL_CNT);
    assign o_empty   = (r_count == '0);
    assign w_do_pop  = i_pop & ~o_empty;
    // A full FIFO can still take a push when the head leaves in the same cycle.
    assign w_do_push = i_push & (~o_full | w_do_pop);
    assign o_data    = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/vpu_wb_unit.sv
// vpu_wb_unit: VPU writeback stage. Pairs issued destination tags with exec
// results in order, buffers them and writes them to the vector register file.
//   clk, rst_n       : clock, asynchronous active-low reset
//   issue_i/dst_id_i : op issued to exec unit with its destination register
//   issue_ready_o    : issue allowed (registered); issue while low is dropped
//   exec_done_i/exec_dout_i : exec unit done pulse and result
//   wb_valid_o/wb_ready_i/wb_addr_o/wb_data_o : register-file write port
//   busy_o           : ops in flight or results buffered
//   err_o            : sticky protocol error (issue while not ready, or done
//                      with no outstanding tag); cleared only by reset
// Build option VPU_WB_BYPASS_EN: an exec result arriving while the result
// buffer is empty is presented on the write port in the same cycle.
module vpu_wb_unit #(
    parameter int DWIDTH    = vpu_pkg::DWIDTH_PER_EXEC,
    parameter int VREG_ID_W = vpu_pkg::VREG_ID_W,
    parameter int DEPTH     = vpu_pkg::VPU_WB_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_i,
    input  logic [VREG_ID_W-1:0] dst_id_i,
    output logic                 issue_ready_o,
    input  logic                 exec_done_i,
    input  logic [DWIDTH-1:0]    exec_dout_i,
    output logic                 wb_valid_o,
    input  logic                 wb_ready_i,
    output logic [VREG_ID_W-1:0] wb_addr_o,
    output logic [DWIDTH-1:0]    wb_data_o,
    output logic                 busy_o,
    output logic                 err_o
);

    import vpu_pkg::vpu_wb_entry_t;

    localparam int            CW        = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = DEPTH[CW-1:0];

    logic                 r_issue_ready;
    logic                 r_err;
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        w_inflight_nxt;

    logic                 w_tag_full;
    logic                 w_tag_empty;
    logic [VREG_ID_W-1:0] w_tag_head;
    logic                 w_res_full;
    logic                 w_res_empty;
    vpu_wb_entry_t        w_res_head;
    vpu_wb_entry_t        w_res_in;

    logic                 w_issue_acc;
    logic                 w_done_ok;
    logic                 w_wr_fire;
    logic                 w_res_push;
    logic                 w_res_pop;

    assign w_issue_acc = issue_i & r_issue_ready & ~w_tag_full;
    assign w_done_ok   = exec_done_i & ~w_tag_empty;
    assign w_wr_fire   = wb_valid_o & wb_ready_i;
    assign w_res_pop   = w_wr_fire & ~w_res_empty;
    assign w_res_in    = '{vreg_id: w_tag_head, data: exec_dout_i};

`ifdef VPU_WB_BYPASS_EN
    // Bypass only from an empty buffer; a result arriving behind a draining
    // head enters the buffer and is written on the next cycle.
    logic w_bypass;
    assign w_bypass   = w_done_ok & w_res_empty;
    assign wb_valid_o = ~w_res_empty | w_bypass;
    assign wb_addr_o  = w_bypass ? w_tag_head  : w_res_head.vreg_id;
    assign wb_data_o  = w_bypass ? exec_dout_i : w_res_head.data;
    assign w_res_push = w_done_ok & ~(w_bypass & wb_ready_i);
`else
    assign wb_valid_o = ~w_res_empty;
    assign wb_addr_o  = w_res_head.vreg_id;
    assign wb_data_o  = w_res_head.data;
    assign w_res_push = w_done_ok;
`endif

    vpu_wb_fifo #(
        .DEPTH (DEPTH),
        .T     (logic [VREG_ID_W-1:0])
    ) u_tag_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_issue_acc),
        .i_data  (dst_id_i),
        .i_pop   (w_done_ok),
        .o_data  (w_tag_head),
        .o_full  (w_tag_full),
        .o_empty (w_tag_empty)
    );

    vpu_wb_fifo #(
        .DEPTH (DEPTH),
        .T     (vpu_wb_entry_t)
    ) u_res_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_res_push),
        .i_data  (w_res_in),
        .i_pop   (w_res_pop),
        .o_data  (w_res_head),
        .o_full  (w_res_full),
        .o_empty (w_res_empty)
    );

    always_comb begin
        w_inflight_nxt = r_inflight;
        if (w_issue_acc && !w_wr_fire) begin
            w_inflight_nxt = r_inflight + 1'b1;
        end else if (!w_issue_acc && w_wr_fire) begin
            w_inflight_nxt = r_inflight - 1'b1;
        end
    end

    // issue_ready is computed from the next in-flight count so it is exact
    // one cycle later; results buffered never exceed ops in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight    <= '0;
            r_issue_ready <= 1'b1;
            r_err         <= 1'b0;
        end else begin
            r_inflight    <= w_inflight_nxt;
            r_issue_ready <= (w_inflight_nxt < DEPTH_CNT);
            r_err         <= r_err
                           | (issue_i & ~r_issue_ready)
                           | (exec_done_i & w_tag_empty)
                           | (w_res_push & w_res_full & ~w_res_pop);
        end
    end

    assign issue_ready_o = r_issue_ready;
    assign err_o         = r_err;
    assign busy_o        = (r_inflight != '0);

endmodule
